// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the fetch stage's instruction-cache request/response signals and
//   its decode-side valid/deq handshake.
//
//   master : the fetch stage (fetch_queue) -- drives the icache request and the
//            queue head toward decode; receives ihit/imemload, redirect, deq.
//   slave  : the environment (icache + decode/execute) -- the mirror image.
//
//   Signals
//     imemREN     fetch -> icache   read request
//     imemaddr    fetch -> icache   request address (fetch PC, word aligned)
//     ihit        icache -> fetch   request serviced, imemload valid
//     imemload    icache -> fetch   fetched instruction word
//     redirect    exec -> fetch     taken branch/jump: flush and refetch
//     redirect_pc exec -> fetch     new fetch target
//     deq         decode -> fetch   decode accepts the head entry
//     valid       fetch -> decode   head entry present
//     instr/pc/pc4 fetch -> decode  head entry contents (0 when !valid)
//     count       fetch -> decode   occupied entries
//     halted      fetch -> out      HALT word fetched, fetching stopped
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              deq;
  logic              valid;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc4;
  logic [CNT_W-1:0]  count;
  logic              halted;

  modport master (
    output imemREN, imemaddr, valid, instr, pc, pc4, count, halted,
    input  ihit, imemload, redirect, redirect_pc, deq
  );

  modport slave (
    input  imemREN, imemaddr, valid, instr, pc, pc4, count, halted,
    output ihit, imemload, redirect, redirect_pc, deq
  );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage. Owns the fetch PC, issues one word request per
//   cycle on the icache port while the queue has room and no HALT has been
//   fetched, and buffers returned words with their PCs in a DEPTH-entry FIFO
//   that decode drains through valid/deq. A redirect flushes everything and
//   restarts fetch at the (word-aligned) target.
//
//   Parameters
//     WORD_W  instruction / PC width (>= 32; HALT opcode lives in [31:26])
//     DEPTH   queue entries, power of two, >= 2
//     PC_INIT fetch PC after reset
//
//   Ports
//     CLK  clock, all state updates on the rising edge
//     RST  synchronous, active-high reset
//     bus  fetch_queue_if.master (icache request/response + decode handshake)
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int                 WORD_W  = 32,
  parameter int                 DEPTH   = 4,
  parameter logic [WORD_W-1:0]  PC_INIT = '0
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_queue_if.master bus
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [5:0]        HALT_OP    = 6'b111111;

  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              halted_q,   halted_d;

  logic [WORD_W-1:0] mem_instr_q [DEPTH];
  logic [WORD_W-1:0] mem_pc_q    [DEPTH];

  logic head_valid;
  logic req;
  logic enq;
  logic deq_fire;
  logic is_halt;

  // Request depends on registered state only, so there is no comb path from
  // ihit/deq to imemREN. A deq on a full queue therefore frees the slot one
  // cycle before the next request goes out.
  always_comb begin
    head_valid = (count_q != '0);
    req        = !halted_q && (count_q != FULL_COUNT);
    enq        = req && bus.ihit && !bus.redirect;
    deq_fire   = bus.deq && head_valid && !bus.redirect;
    is_halt    = (bus.imemload[31:26] == HALT_OP);
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    halted_d   = halted_q;

    if (bus.redirect) begin
      // Flush wins over any same-cycle ihit/deq; target is forced word aligned.
      fetch_pc_d = bus.redirect_pc & ~WORD_W'(3);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      halted_d   = 1'b0;
    end else begin
      if (enq) begin
        // Pointers wrap for free because DEPTH is a power of two.
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + WORD_W'(4);
        if (is_halt) halted_d = 1'b1;
      end
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({enq, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= PC_INIT;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read while count says it holds data, and the outputs below are gated by
  // head_valid, so stale contents are never visible.
  always_ff @(posedge CLK) begin
    if (enq && !RST) begin
      mem_instr_q[wr_ptr_q] <= bus.imemload;
      mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign bus.imemREN  = req;
  assign bus.imemaddr = fetch_pc_q;
  assign bus.valid    = head_valid;
  assign bus.instr    = head_valid ? mem_instr_q[rd_ptr_q] : '0;
  assign bus.pc       = head_valid ? mem_pc_q[rd_ptr_q] : '0;
  assign bus.pc4      = head_valid ? (mem_pc_q[rd_ptr_q] + WORD_W'(4)) : '0;
  assign bus.count    = count_q;
  assign bus.halted   = halted_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch stage: owns the fetch PC, issues requests on the instruction-cache port, and buffers returned words with their PCs in a DEPTH-entry FIFO. Decode consumes entries through a valid/deq handshake. Redirect flushes the queue. Fetching stops after a HALT word is fetched. It replaces the single-entry PC/IF latch in front of decode and decouples icache hits from decode stalls.

Parameters:
PC_INIT, 32'h0, fetch PC after reset.
DEPTH, 4, queue entries; power of two, >= 2.
WORD_W, 32, instruction and PC width.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  reset; synchronous, active-high.
imemREN  out  1  instruction read request.
imemaddr  out  WORD_W  request address = fetch PC.
ihit  in  1  request serviced this cycle; imemload is valid.
imemload  in  WORD_W  fetched instruction.
redirect  in  1  branch/jump resolved taken; flush and refetch.
redirect_pc  in  WORD_W  new fetch target.
deq  in  1  decode accepts head entry this cycle.
valid  out  1  head entry present.
instr  out  WORD_W  head instruction; 0 (nop) when !valid.
pc  out  WORD_W  head PC; 0 when !valid.
pc4  out  WORD_W  head PC + 4; 0 when !valid.
count  out  $clog2(DEPTH+1)  occupied entries.
halted  out  1  HALT word fetched; fetching stopped.

Behaviour:
- Reset (RST high at an edge):
  - fetch_pc = PC_INIT; rd_ptr = 0, wr_ptr = 0; count = 0; halted = 0.
  - Outputs after reset: valid = 0, instr/pc/pc4 = 0, imemaddr = PC_INIT, imemREN = 1.
  - Reset mid-request discards any ihit in that cycle.
- imemREN = !halted && count != DEPTH. It depends on registered state only; there is no combinational path from deq or ihit.
- imemaddr = fetch_pc. Its low 2 bits are always 0.
- Enqueue: occurs when imemREN && ihit && !redirect.
  - Writes {fetch_pc, imemload} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - fetch_pc += 4 (wraps modulo 2^WORD_W).
- Dequeue: occurs when deq && valid && !redirect. rd_ptr advances modulo DEPTH. deq while !valid is ignored.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged when both occur or neither occurs.
- Full queue (count == DEPTH): no request is issued. A deq in that cycle frees a slot; the request resumes the next cycle (1-cycle bubble by design).
- Empty queue: valid = 0 and instr/pc/pc4 = 0. An enqueued word becomes visible the cycle after ihit (1-cycle fetch-to-decode latency; no bypass).
- HALT detect: an enqueued word with imemload[31:26] == 6'b111111 sets halted at the same edge.
  - The HALT word itself is enqueued.
  - fetch_pc still increments.
  - halted forces imemREN = 0 until redirect or reset.
  - Queued entries still drain normally.
- Redirect has the highest priority:
  - Pointers and count clear; halted clears.
  - fetch_pc = {redirect_pc[WORD_W-1:2], 2'b00}.
  - Any ihit or deq in the same cycle is discarded.
  - The next cycle shows valid = 0 and imemaddr = the new target.
- RST overrides redirect.
- Simultaneous enqueue + dequeue at count == 1: count stays 1 and the head advances to the new word.
- Pointer wrap: correct ordering is required across an arbitrary number of wraps.
- Storage is plain flops; no reset is required on data entries. Output gating by valid guarantees 0 values when empty.

Test Plan:
- Reset, ihit tied 1, deq tied 1, memory returns instr = PC ^ 32'hA5A5_0000 → first valid cycle shows pc = 0, instr = 32'hA5A5_0000, pc4 = 4; pc then increments by 4 every cycle; count stays 1.
- DEPTH = 4, ihit = 1, deq = 0 → count reaches 4 after 4 cycles; imemREN drops to 0 with imemaddr = 16. One deq then gives imemREN = 1 next cycle and entry pc = 16 enqueued after it; head pc order is 0, 4, 8, 12, 16.
- Queue holds pcs 0, 4, 8; assert redirect with redirect_pc = 32'h0000_0103 together with ihit and deq → next cycle valid = 0, count = 0, imemaddr = 32'h100; the first entry after refill has pc = 32'h100.
- Word 32'hFC00_0000 returned at pc 8 → halted = 1 next cycle and imemREN = 0. Entries 0, 4, 8 drain in order, then valid = 0 indefinitely. A redirect to 0x40 clears halted and resumes fetch at 0x40.
- Random ihit/deq at 50% for 1000 cycles with DEPTH = 8 → scoreboard confirms in-order, no drop/duplicate, count == scoreboard size, and count never exceeds 8 across multiple pointer wraps.
- RST asserted mid-stream while count = 3 and ihit = 1 → next cycle count = 0, valid = 0, imemaddr = PC_INIT, halted = 0.
